// File: rtl/pc_pkg.sv
// Shared types and constants for the next-PC generator.
package pc_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StTrap
  } pc_state_e;

  localparam int unsigned INSN_BYTES = 4;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch/control bundle between pc_gen (master) and its environment (slave).
interface pc_gen_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             pc_ready_i;
  logic             jump_i;
  logic             jalr_i;
  logic             branch_i;
  logic             bne_i;
  logic             zero_i;
  logic [XLEN-1:0]  jal_imm_i;
  logic [XLEN-1:0]  jalr_imm_i;
  logic [XLEN-1:0]  branch_imm_i;
  logic [XLEN-1:0]  rs1_data_i;
  logic             trap_ack_i;
  logic [XLEN-1:0]  trap_vec_i;
  logic [XLEN-1:0]  pc_o;
  logic             pc_valid_o;
  logic             misalign_o;
  logic [XLEN-1:0]  misalign_addr_o;
  logic [CNT_W-1:0] retire_cnt_o;

  modport master (
    input  pc_ready_i, jump_i, jalr_i, branch_i, bne_i, zero_i,
    input  jal_imm_i, jalr_imm_i, branch_imm_i, rs1_data_i, trap_ack_i, trap_vec_i,
    output pc_o, pc_valid_o, misalign_o, misalign_addr_o, retire_cnt_o
  );

  modport slave (
    output pc_ready_i, jump_i, jalr_i, branch_i, bne_i, zero_i,
    output jal_imm_i, jalr_imm_i, branch_imm_i, rs1_data_i, trap_ack_i, trap_vec_i,
    input  pc_o, pc_valid_o, misalign_o, misalign_addr_o, retire_cnt_o
  );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC target select. With PC_MISALIGN_TRAP_EN the raw target and
// its misalignment flag are exposed; otherwise the low two bits are silently cleared.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            jump,
  input  logic            jalr,
  input  logic            branch,
  input  logic            bne,
  input  logic            zero,
  input  logic [XLEN-1:0] jal_imm,
  input  logic [XLEN-1:0] jalr_imm,
  input  logic [XLEN-1:0] branch_imm,
  input  logic [XLEN-1:0] rs1_data,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misalign,
`endif
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] raw;

  always_comb begin
    raw = pc + XLEN'(INSN_BYTES);
    if (jump && jalr) begin
      raw = (rs1_data + jalr_imm) & ~XLEN'(1);
    end else if (jump) begin
      raw = pc + jal_imm;
    end else if (bne && !zero) begin
      raw = pc + branch_imm;
    end else if (branch && !bne && zero) begin
      raw = pc + branch_imm;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign target   = raw;
  assign misalign = raw[1];
`else
  assign target = raw & ~XLEN'(3);
`endif

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator: BOOT/RUN/TRAP FSM, PC register and retire counter.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     CNT_W     = 32
) (
  input logic      clk,
  input logic      rst,
  pc_gen_if.master bus
);

  pc_state_e        state_q;
  logic [XLEN-1:0]  pc_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  target;
  logic             fire;
`ifdef PC_MISALIGN_TRAP_EN
  logic             target_mis;
  logic             mis_q;
  logic [XLEN-1:0]  addr_q;
`endif

  // valid_q is only ever set in RUN, so it alone qualifies the handshake.
  assign fire = valid_q & bus.pc_ready_i;

  pc_target_calc #(
    .XLEN(XLEN)
  ) u_target_calc (
    .pc        (pc_q),
    .jump      (bus.jump_i),
    .jalr      (bus.jalr_i),
    .branch    (bus.branch_i),
    .bne       (bus.bne_i),
    .zero      (bus.zero_i),
    .jal_imm   (bus.jal_imm_i),
    .jalr_imm  (bus.jalr_imm_i),
    .branch_imm(bus.branch_imm_i),
    .rs1_data  (bus.rs1_data_i),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign  (target_mis),
`endif
    .target    (target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      cnt_q   <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
      addr_q  <= '0;
`endif
    end else begin
      case (state_q)
        StBoot: begin
          state_q <= StRun;
          valid_q <= 1'b1;
        end
        StRun: begin
          if (fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
`ifdef PC_MISALIGN_TRAP_EN
            if (target_mis) begin
              state_q <= StTrap;
              valid_q <= 1'b0;
              mis_q   <= 1'b1;
              addr_q  <= target;
            end else begin
              pc_q <= target;
            end
`else
            pc_q <= target;
`endif
          end
        end
`ifdef PC_MISALIGN_TRAP_EN
        StTrap: begin
          if (bus.trap_ack_i) begin
            state_q <= StRun;
            valid_q <= 1'b1;
            mis_q   <= 1'b0;
            pc_q    <= bus.trap_vec_i & ~XLEN'(3);
          end
        end
`endif
        default: begin
          state_q <= StBoot;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.pc_valid_o   = valid_q;
  assign bus.retire_cnt_o = cnt_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.misalign_o      = mis_q;
  assign bus.misalign_addr_o = addr_q;
`else
  assign bus.misalign_o      = 1'b0;
  assign bus.misalign_addr_o = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios then randomized cycles against a
// behavioural model of the PC/trap rules.
module tb_pc_gen;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;
  localparam logic [31:0] RVEC  = 32'h100;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_TRAP = 2;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_gen_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  pc_gen #(
    .XLEN     (XLEN),
    .RESET_VEC(RVEC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int          m_state;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_mis;
  logic [31:0] m_addr;
  logic [31:0] m_cnt;

  function automatic logic [31:0] spec_target();
    if (bus.jump_i && bus.jalr_i) return (bus.rs1_data_i + bus.jalr_imm_i) & 32'hFFFF_FFFE;
    if (bus.jump_i) return m_pc + bus.jal_imm_i;
    if (bus.bne_i && !bus.zero_i) return m_pc + bus.branch_imm_i;
    if (bus.branch_i && !bus.bne_i && bus.zero_i) return m_pc + bus.branch_imm_i;
    return m_pc + 32'd4;
  endfunction

  task automatic model_update();
    logic [31:0] t;
    if (rst) begin
      m_state = M_BOOT; m_pc = RVEC; m_mis = 1'b0; m_addr = '0; m_cnt = '0;
    end else if (m_state == M_BOOT) begin
      m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (bus.pc_ready_i) begin
        t = spec_target();
        m_cnt = m_cnt + 1;
        if (TRAP_EN && t[1]) begin
          m_mis = 1'b1; m_addr = t; m_state = M_TRAP;
        end else begin
          m_pc = TRAP_EN ? t : (t & 32'hFFFF_FFFC);
        end
      end
    end else if (bus.trap_ack_i) begin
      m_pc = bus.trap_vec_i & 32'hFFFF_FFFC; m_mis = 1'b0; m_state = M_RUN;
    end
    m_valid = (m_state == M_RUN);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, bus.pc_o, m_pc);
    chk({tag, ".valid"}, 32'(bus.pc_valid_o), 32'(m_valid));
    chk({tag, ".mis"}, 32'(bus.misalign_o), 32'(m_mis));
    chk({tag, ".addr"}, bus.misalign_addr_o, m_addr);
    chk({tag, ".cnt"}, bus.retire_cnt_o, m_cnt);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    bus.pc_ready_i = 1'b0; bus.jump_i = 1'b0; bus.jalr_i = 1'b0; bus.branch_i = 1'b0;
    bus.bne_i = 1'b0; bus.zero_i = 1'b0; bus.jal_imm_i = '0; bus.jalr_imm_i = '0;
    bus.branch_imm_i = '0; bus.rs1_data_i = '0; bus.trap_ack_i = 1'b0; bus.trap_vec_i = '0;
  endtask

  // Redirect with a JALR so each scenario starts from a known PC.
  task automatic goto(input logic [31:0] a);
    idle();
    bus.pc_ready_i = 1'b1; bus.jump_i = 1'b1; bus.jalr_i = 1'b1; bus.rs1_data_i = a;
    step("goto");
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    m_state = M_BOOT; m_pc = RVEC; m_valid = 1'b0; m_mis = 1'b0; m_addr = '0; m_cnt = '0;
    step("rst0");
    step("rst1");
    rst = 1'b0;
    chk("boot.pc", bus.pc_o, 32'h100);
    chk("boot.valid", 32'(bus.pc_valid_o), 32'd0);
    step("boot_run");
    chk("run.valid", 32'(bus.pc_valid_o), 32'd1);

    bus.pc_ready_i = 1'b1;
    step("seq1"); step("seq2"); step("seq3");
    chk("seq.pc", bus.pc_o, 32'h10C);
    chk("seq.cnt", bus.retire_cnt_o, 32'd3);
    bus.pc_ready_i = 1'b0; bus.jump_i = 1'b1;
    step("hold");
    chk("hold.pc", bus.pc_o, 32'h10C);

    goto(32'h200);
    bus.pc_ready_i = 1'b1; bus.jump_i = 1'b1; bus.jal_imm_i = 32'hFFFF_FFF8;
    step("jal");
    chk("jal.pc", bus.pc_o, 32'h1F8);
    idle();
    bus.pc_ready_i = 1'b1; bus.jump_i = 1'b1; bus.jalr_i = 1'b1;
    bus.rs1_data_i = 32'h1001; bus.jalr_imm_i = 32'd4;
    step("jalr");
    chk("jalr.pc", bus.pc_o, 32'h1004);

    goto(32'h300);
    bus.pc_ready_i = 1'b1; bus.bne_i = 1'b1; bus.branch_imm_i = 32'h10;
    step("bne_taken");
    chk("bne_taken.pc", bus.pc_o, 32'h310);
    goto(32'h300);
    bus.pc_ready_i = 1'b1; bus.bne_i = 1'b1; bus.zero_i = 1'b1; bus.branch_imm_i = 32'h10;
    step("bne_nt");
    chk("bne_nt.pc", bus.pc_o, 32'h304);
    goto(32'h300);
    bus.pc_ready_i = 1'b1; bus.branch_i = 1'b1; bus.zero_i = 1'b1; bus.branch_imm_i = 32'h10;
    step("beq");
    chk("beq.pc", bus.pc_o, 32'h310);

    goto(32'h400);
    bus.pc_ready_i = 1'b1; bus.jump_i = 1'b1; bus.jal_imm_i = 32'd2;
    step("mis_jal");
    chk("mis_jal.pc", bus.pc_o, 32'h400);
    chk("mis_jal.mis", 32'(bus.misalign_o), TRAP_EN ? 32'd1 : 32'd0);
    chk("mis_jal.addr", bus.misalign_addr_o, TRAP_EN ? 32'h402 : 32'h0);
    chk("mis_jal.valid", 32'(bus.pc_valid_o), TRAP_EN ? 32'd0 : 32'd1);
    idle();
    bus.pc_ready_i = 1'b1;
    step("trap_wait");
    bus.pc_ready_i = 1'b0; bus.trap_ack_i = 1'b1; bus.trap_vec_i = 32'h803;
    step("trap_ack");
    chk("trap_ack.pc", bus.pc_o, TRAP_EN ? 32'h800 : 32'h404);
    chk("trap_ack.valid", 32'(bus.pc_valid_o), 32'd1);

    goto(32'hFFFF_FFFC);
    bus.pc_ready_i = 1'b1;
    step("wrap");
    chk("wrap.pc", bus.pc_o, 32'h0);

    goto(32'h400);
    bus.pc_ready_i = 1'b1; bus.jump_i = 1'b1; bus.jal_imm_i = 32'd2;
    step("mis2");
    idle();
    rst = 1'b1;
    step("rst_trap");
    rst = 1'b0;
    chk("rst_trap.mis", 32'(bus.misalign_o), 32'd0);
    chk("rst_trap.pc", bus.pc_o, 32'h100);

    for (int i = 0; i < 400; i++) begin
      rst               = ($urandom_range(0, 59) == 0);
      bus.pc_ready_i    = ($urandom_range(0, 3) != 0);
      bus.jump_i        = ($urandom_range(0, 3) == 0);
      bus.jalr_i        = 1'($urandom);
      bus.branch_i      = 1'($urandom);
      bus.bne_i         = 1'($urandom);
      bus.zero_i        = 1'($urandom);
      bus.jal_imm_i     = 32'($urandom_range(0, 255)) * 2 - 32'd256;
      bus.jalr_imm_i    = 32'($urandom_range(0, 255)) - 32'd128;
      bus.branch_imm_i  = 32'($urandom_range(0, 127)) * 2 - 32'd128;
      bus.rs1_data_i    = $urandom;
      bus.trap_ack_i    = ($urandom_range(0, 2) == 0);
      bus.trap_vec_i    = $urandom;
      step("rand");
    end
    rst = 1'b0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
